// File: rtl/code_conv_pkg.sv
// Shared mode encodings and nibble width for the code converter pipeline.
package code_conv_pkg;
    localparam logic [1:0] MODE_B2G     = 2'b00;
    localparam logic [1:0] MODE_G2B     = 2'b01;
    localparam logic [1:0] MODE_BCD2EX3 = 2'b10;
    localparam logic [1:0] MODE_EX32BCD = 2'b11;
    localparam int         NIB_W        = 4;
endpackage

// File: rtl/nibble_bcd_ex3.sv
// One-nibble BCD <-> excess-3 converter; invalid codes produce 0 and raise inv_o.
module nibble_bcd_ex3
    import code_conv_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             to_bcd_i,
    output logic [NIB_W-1:0] nib_o,
    output logic             inv_o
);
    always_comb begin
        nib_o = '0;
        inv_o = 1'b0;
        if (to_bcd_i) begin
            if (nib_i < 4'd3 || nib_i > 4'd12) inv_o = 1'b1;
            else                               nib_o = nib_i - 4'd3;
        end else begin
            if (nib_i > 4'd9) inv_o = 1'b1;
            else              nib_o = nib_i + 4'd3;
        end
    end
endmodule

// File: rtl/code_converter_pipe.sv
// Registered binary/Gray/BCD/excess-3 converter with one-stage valid/ready
// output register and saturating conversion / error counters.
module code_converter_pipe
    import code_conv_pkg::*;
#(
    parameter int DIGITS = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [1:0]            out_mode,
    output logic [CNT_W-1:0]      conv_cnt,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int W = NIB_W * DIGITS;

    logic [W-1:0]      gray_w, bin_w, bcd_w, res_data;
    logic [DIGITS-1:0] nib_inv;
    logic              res_err, acc_bit, accept, retire;

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [1:0]        out_mode_q, out_mode_d;
    logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d, err_cnt_q, err_cnt_d;

    // Gray conversion spans nibble boundaries, so it stays at full width.
    always_comb begin
        gray_w  = in_data ^ (in_data >> 1);
        bin_w   = '0;
        acc_bit = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc_bit  = acc_bit ^ in_data[i];
            bin_w[i] = acc_bit;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_nib
        nibble_bcd_ex3 u_nib (
            .nib_i    (in_data[d*NIB_W +: NIB_W]),
            .to_bcd_i (mode[0]),
            .nib_o    (bcd_w[d*NIB_W +: NIB_W]),
            .inv_o    (nib_inv[d])
        );
    end

    always_comb begin
        res_data = bcd_w;
        res_err  = |nib_inv;
        case (mode)
            MODE_B2G: begin res_data = gray_w; res_err = 1'b0; end
            MODE_G2B: begin res_data = bin_w;  res_err = 1'b0; end
            default: ;
        endcase
    end

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign retire   = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_mode_d  = out_mode_q;
        conv_cnt_d  = conv_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_err_d   = res_err;
            out_mode_d  = mode;
            if (conv_cnt_q != '1) conv_cnt_d = conv_cnt_q + CNT_W'(1);
            if (res_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_mode_q  <= 2'b00;
            conv_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_mode_q  <= out_mode_d;
            conv_cnt_q  <= conv_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_mode  = out_mode_q;
    assign conv_cnt  = conv_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: doc/code_converter_pipe.md
Name: code_converter_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational code converter.
- Converts a DIGITS×4-bit word between binary, Gray, BCD and excess-3 codes, chosen by a runtime mode input.
- One-stage valid/ready pipeline with backpressure, per-result error flag, and saturating conversion and error counters.
- Sits between a stimulus or switch source and a display or comparison stage on the lab board datapath.

Parameters:
- DIGITS, 1, number of 4-bit nibbles; data width W = 4*DIGITS.
- CNT_W, 8, width of the conversion and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  W  source code word.
- mode  input  2  00 bin→gray, 01 gray→bin, 10 bcd→ex3, 11 ex3→bcd; sampled with in_data.
- out_valid  output  1  out_data, out_err and out_mode are valid.
- out_ready  input  1  downstream accepts the output.
- out_data  output  W  converted word.
- out_err  output  1  at least one nibble of this result was an invalid code.
- out_mode  output  2  mode that produced out_data.
- conv_cnt  output  CNT_W  accepted conversions, saturating.
- err_cnt  output  CNT_W  accepted conversions with out_err=1, saturating.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_err=0, out_mode=0, conv_cnt=0, err_cnt=0.
  - Reset applies immediately, mid-transfer included; a held result is discarded.
  - in_ready=1 on the first cycle after release.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational, no bubble).
  - Accept occurs when in_valid & in_ready.
  - On accept, the output register loads the conversion result on the next rising edge and out_valid=1. Latency is one cycle.
  - Output retire occurs when out_valid & out_ready.
  - Retire with no accept sets out_valid=0.
  - Retire with a simultaneous accept loads the new word and keeps out_valid=1, giving full throughput.
  - While out_valid & ~out_ready, out_data, out_err and out_mode are held stable.
- Bin→gray, whole W bits: g = b ^ (b >> 1).
- Gray→bin, whole W bits: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Gray modes never set err.
- BCD→ex3, per nibble: nibble > 9 is invalid. Otherwise the output nibble is nibble + 3 (mod 16).
- Ex3→BCD, per nibble: nibble < 3 or nibble > 12 is invalid. Otherwise the output nibble is nibble − 3.
- Invalid nibble: that output nibble = 4'h0, other nibbles convert normally, and out_err = OR of all nibble errors.
- Counters update on accept:
  - conv_cnt += 1; if the result error is set, err_cnt += 1.
  - Both saturate at all-ones with no wrap.
  - Neither counter changes on stall cycles.
- Mode changes while in_valid=0 or while stalled have no effect; only the mode sampled at accept matters.

Decomposition:
- Package code_conv_pkg: mode localparams MODE_B2G=2'b00, MODE_G2B=2'b01, MODE_BCD2EX3=2'b10, MODE_EX32BCD=2'b11; NIB_W=4.
- Sub-module nibble_bcd_ex3: combinational, 4-bit in, direction bit, 4-bit out plus invalid flag. Instantiated DIGITS times in a generate loop.
- Gray logic stays inline at full width, because it crosses nibble boundaries.

Test Plan:
- DIGITS=1, out_ready=1, sweep in_data 0..15 in each of the 4 modes, one word per cycle. Required results:
  - mode 00, 4'b1011 → out_data 4'b1110.
  - mode 01, 4'b1110 → 4'b1011.
  - mode 10, 4'b0111 → 4'b1010.
  - mode 11, 4'b1100 → 4'b1001.
  - Every out_valid appears exactly 1 cycle after accept.
- DIGITS=1, mode 10, in_data 4'b1010 → out_data 4'b0000, out_err=1, err_cnt increments by 1. Mode 11, in_data 4'b0010 → out_err=1.
- DIGITS=2, mode 10, in_data 8'h9A → out_data 8'hC0, out_err=1. in_data 8'h45 → 8'h78, out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 and out_data is stable throughout.
  - On release, the next word is accepted in the same cycle and no word is lost or duplicated.
  - conv_cnt equals the number of handshakes.
- Pull rst_n low between clock edges while out_valid=1.
  - out_valid, out_data, conv_cnt and err_cnt clear immediately.
  - After release, in_ready=1 and conversion resumes correctly.
- CNT_W=2: perform 5 invalid accepts → conv_cnt=3 and err_cnt=3, both saturated.
